// File: rtl/rec_play_ctrl.sv
// Record/playback controller: codec init sequencing plus record/pause/play/stop FSM
// over N_TRACKS equal SRAM slots, with a per-slot recorded-length table.
module rec_play_ctrl #(
  parameter  int ADDR_W        = 20,
  parameter  int N_TRACKS      = 4,
  parameter  int I2C_START_CYC = 2048,
  parameter  int SPEED_W       = 3,
  localparam int TRK_W         = $clog2(N_TRACKS),
  localparam int OFF_W         = ADDR_W - TRK_W
) (
  input  logic               i_clk,
  input  logic               i_rst_n,
  input  logic               i_key_rec,
  input  logic               i_key_play,
  input  logic               i_key_stop,
  input  logic [TRK_W-1:0]   i_track,
  input  logic [SPEED_W-1:0] i_speed,
  input  logic               i_fast,
  input  logic               i_interp,
  input  logic               i_i2c_fin,
  input  logic [ADDR_W-1:0]  i_rec_addr,
  input  logic [ADDR_W-1:0]  i_play_addr,
  output logic               o_i2c_start,
  output logic               o_rec_start,
  output logic               o_rec_pause,
  output logic               o_rec_stop,
  output logic               o_dsp_start,
  output logic               o_dsp_pause,
  output logic               o_dsp_stop,
  output logic               o_play_en,
  output logic               o_sram_wr,
  output logic [ADDR_W-1:0]  o_track_base,
  output logic [ADDR_W-1:0]  o_track_end,
  output logic [SPEED_W-1:0] o_speed,
  output logic               o_fast,
  output logic               o_slow_lin,
  output logic               o_done,
  output logic               o_err,
  output logic [2:0]         o_state
);

  typedef enum logic [2:0] {
    S_I2C        = 3'd0,
    S_IDLE       = 3'd1,
    S_RECD       = 3'd2,
    S_RECD_PAUSE = 3'd3,
    S_PLAY       = 3'd4,
    S_PLAY_PAUSE = 3'd5
  } state_t;

  localparam int              CNT_W   = $clog2(I2C_START_CYC + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(I2C_START_CYC);

  state_t              r_state;
  logic [CNT_W-1:0]    r_cnt;
  logic [TRK_W-1:0]    r_trk;
  logic [OFF_W-1:0]    r_len [N_TRACKS];
  logic                r_i2c_start, r_rec_start, r_rec_pause, r_rec_stop;
  logic                r_dsp_start, r_dsp_pause, r_dsp_stop;
  logic                r_play_en, r_sram_wr, r_done, r_err, r_fast, r_slow_lin;
  logic [SPEED_W-1:0]  r_speed;

  logic [ADDR_W-1:0]   w_track_end;
  logic                w_rec_full, w_play_end, w_sel_empty;

  assign w_track_end = {r_trk, r_len[r_trk]};
  assign w_rec_full  = (i_rec_addr == {r_trk, {OFF_W{1'b1}}});
  assign w_play_end  = (i_play_addr >= w_track_end);
  assign w_sel_empty = (r_len[i_track] == '0);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_state     <= S_I2C;
      r_cnt       <= '0;
      r_trk       <= '0;
      for (int i = 0; i < N_TRACKS; i++) r_len[i] <= '0;
      r_i2c_start <= 1'b0;
      r_rec_start <= 1'b0;
      r_rec_pause <= 1'b0;
      r_rec_stop  <= 1'b0;
      r_dsp_start <= 1'b0;
      r_dsp_pause <= 1'b0;
      r_dsp_stop  <= 1'b0;
      r_play_en   <= 1'b0;
      r_sram_wr   <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      r_speed     <= '0;
      r_fast      <= 1'b0;
      r_slow_lin  <= 1'b0;
    end else begin
      r_i2c_start <= 1'b0;
      r_rec_start <= 1'b0;
      r_rec_pause <= 1'b0;
      r_rec_stop  <= 1'b0;
      r_dsp_start <= 1'b0;
      r_dsp_pause <= 1'b0;
      r_dsp_stop  <= 1'b0;
      r_done      <= 1'b0;
      r_err       <= 1'b0;
      case (r_state)
        S_I2C: begin
          if (r_cnt != CNT_MAX) r_cnt <= r_cnt + 1'b1;
          if (i_i2c_fin) r_state <= S_IDLE;
          else           r_i2c_start <= (r_cnt < CNT_MAX);
        end
        S_IDLE: begin
          if (i_key_rec) begin
            r_trk       <= i_track;
            r_rec_start <= 1'b1;
            r_sram_wr   <= 1'b1;
            r_state     <= S_RECD;
          end else if (i_key_play) begin
            if (w_sel_empty) begin
              r_err <= 1'b1;
            end else begin
              r_trk       <= i_track;
              r_speed     <= i_speed;
              r_fast      <= i_fast;
              r_slow_lin  <= i_interp;
              r_dsp_start <= 1'b1;
              r_play_en   <= 1'b1;
              r_state     <= S_PLAY;
            end
          end
        end
        S_RECD, S_RECD_PAUSE: begin
          // Full-slot detection only runs while the recorder is actually writing.
          if (i_key_stop) begin
            r_rec_stop   <= 1'b1;
            r_done       <= (r_state == S_RECD) && w_rec_full;
            r_len[r_trk] <= i_rec_addr[OFF_W-1:0];
            r_sram_wr    <= 1'b0;
            r_state      <= S_IDLE;
          end else if (r_state == S_RECD && w_rec_full) begin
            r_rec_stop   <= 1'b1;
            r_done       <= 1'b1;
            r_len[r_trk] <= '1;
            r_sram_wr    <= 1'b0;
            r_state      <= S_IDLE;
          end else if (i_key_rec) begin
            if (r_state == S_RECD) begin
              r_rec_pause <= 1'b1;
              r_sram_wr   <= 1'b0;
              r_state     <= S_RECD_PAUSE;
            end else begin
              r_rec_start <= 1'b1;
              r_sram_wr   <= 1'b1;
              r_state     <= S_RECD;
            end
          end
        end
        S_PLAY, S_PLAY_PAUSE: begin
          if (i_key_stop) begin
            r_dsp_stop <= 1'b1;
            r_done     <= (r_state == S_PLAY) && w_play_end;
            r_play_en  <= 1'b0;
            r_state    <= S_IDLE;
          end else if (r_state == S_PLAY && w_play_end) begin
            r_dsp_stop <= 1'b1;
            r_done     <= 1'b1;
            r_play_en  <= 1'b0;
            r_state    <= S_IDLE;
          end else if (i_key_play) begin
            if (r_state == S_PLAY) begin
              r_dsp_pause <= 1'b1;
              r_play_en   <= 1'b0;
              r_state     <= S_PLAY_PAUSE;
            end else begin
              r_speed     <= i_speed;
              r_fast      <= i_fast;
              r_slow_lin  <= i_interp;
              r_dsp_start <= 1'b1;
              r_play_en   <= 1'b1;
              r_state     <= S_PLAY;
            end
          end
        end
        default: r_state <= S_I2C;
      endcase
    end
  end

  assign o_i2c_start  = r_i2c_start;
  assign o_rec_start  = r_rec_start;
  assign o_rec_pause  = r_rec_pause;
  assign o_rec_stop   = r_rec_stop;
  assign o_dsp_start  = r_dsp_start;
  assign o_dsp_pause  = r_dsp_pause;
  assign o_dsp_stop   = r_dsp_stop;
  assign o_play_en    = r_play_en;
  assign o_sram_wr    = r_sram_wr;
  assign o_track_base = {r_trk, {OFF_W{1'b0}}};
  assign o_track_end  = w_track_end;
  assign o_speed      = r_speed;
  assign o_fast       = r_fast;
  assign o_slow_lin   = r_slow_lin;
  assign o_done       = r_done;
  assign o_err        = r_err;
  assign o_state      = r_state;

endmodule

// File: doc/rec_play_ctrl.md
Name: rec_play_ctrl

Overview:
Parametrised record/playback controller for the WM8731 audio path. It sequences codec I2C initialisation and runs the record/pause/play/stop FSM that drives the recorder, DSP and player blocks. SRAM is split into N_TRACKS equal slots, and the controller keeps a per-track recorded-length table. Both record and playback stop automatically at slot boundaries.

Parameters:
ADDR_W, 20, SRAM word-address width
N_TRACKS, 4, number of equal SRAM slots; power of 2, >=2; TRK_W=log2(N_TRACKS), OFF_W=ADDR_W-TRK_W
I2C_START_CYC, 2048, cycles o_i2c_start is held high after reset
SPEED_W, 3, width of the speed field

Ports:
i_clk  in  1  system clock
i_rst_n  in  1  asynchronous reset, active-low
i_key_rec  in  1  record/pause key, single-cycle debounced pulse
i_key_play  in  1  play/pause key, single-cycle pulse
i_key_stop  in  1  stop key, single-cycle pulse
i_track  in  TRK_W  selected slot
i_speed  in  SPEED_W  playback speed factor
i_fast  in  1  1=fast, 0=slow
i_interp  in  1  slow mode: 0=constant, 1=linear interpolation
i_i2c_fin  in  1  I2C initialiser finished
i_rec_addr  in  ADDR_W  recorder's current write address
i_play_addr  in  ADDR_W  DSP's current read address
o_i2c_start  out  1  I2C initialiser start
o_rec_start, o_rec_pause, o_rec_stop  out  1 each  recorder command pulses
o_dsp_start, o_dsp_pause, o_dsp_stop  out  1 each  DSP command pulses
o_play_en  out  1  player enable (level)
o_sram_wr  out  1  1 = SRAM driven by recorder
o_track_base  out  ADDR_W  {trk_r, OFF_W'0}
o_track_end  out  ADDR_W  {trk_r, len[trk_r]}
o_speed  out  SPEED_W  latched speed
o_fast, o_slow_lin  out  1 each  latched mode
o_done  out  1  pulse on auto-stop (record full or playback end)
o_err  out  1  pulse when play is requested on an empty track
o_state  out  3  FSM state code

Behaviour:
- All outputs are registered. Command pulses last exactly 1 cycle and appear the cycle after the triggering key or condition.
- Reset values: state=I2C (code 0); all pulses 0; o_play_en=0; o_sram_wr=0; trk_r=0; len[*]=0; o_speed=0; o_fast=0; o_slow_lin=0; start counter=0.
- State codes: I2C=0, IDLE=1, RECD=2, RECD_PAUSE=3, PLAY=4, PLAY_PAUSE=5.
- I2C state:
  - o_i2c_start is high for the first I2C_START_CYC cycles after reset, then low.
  - Move to IDLE the cycle after i_i2c_fin=1, regardless of the counter. o_i2c_start is forced 0 on leaving.
  - All keys are ignored while in I2C.
- IDLE:
  - rec key: latch trk_r=i_track, pulse o_rec_start, go to RECD.
  - play key with len[i_track]!=0: latch trk_r, speed and mode; pulse o_dsp_start; set o_play_en=1; go to PLAY.
  - play key with len[i_track]==0: pulse o_err, stay in IDLE.
  - rec and play in the same cycle: rec wins.
  - stop key: no effect.
- RECD:
  - rec key: pulse o_rec_pause, go to RECD_PAUSE.
  - stop key: pulse o_rec_stop, set len[trk_r]=i_rec_addr[OFF_W-1:0], go to IDLE.
  - i_rec_addr==o_track_base+2^OFF_W-1 (slot full): pulse o_rec_stop and o_done, set len[trk_r]=all ones, go to IDLE.
- RECD_PAUSE:
  - rec key: pulse o_rec_start, go to RECD.
  - stop key: same as stop in RECD.
- PLAY:
  - play key: pulse o_dsp_pause, set o_play_en=0, go to PLAY_PAUSE.
  - stop key: pulse o_dsp_stop, set o_play_en=0, go to IDLE.
  - i_play_addr>=o_track_end (full-width compare): pulse o_dsp_stop and o_done, set o_play_en=0, go to IDLE.
- PLAY_PAUSE:
  - play key: re-latch speed and mode, pulse o_dsp_start, set o_play_en=1, go to PLAY.
  - stop key: same as stop in PLAY.
- Keys not listed for a state are ignored (e.g. rec in PLAY, play in RECD).
- Stop has priority over every other key. An auto-stop condition coincident with stop produces a single stop pulse plus o_done.
- o_sram_wr=1 only in RECD.
- trk_r, o_speed, o_fast and o_slow_lin are frozen between latch points; changes to i_track or i_speed mid-operation have no effect.
- Re-recording a track overwrites its len only when that recording stops.
- Asynchronous reset mid-operation returns to I2C and clears len[*]; all stored tracks are invalidated.

Test Plan:
- Reset, i_i2c_fin pulse at cycle 100 -> o_i2c_start=1 cycles 1..100, state=IDLE at cycle 101, o_i2c_start=0; rec key at cycle 50 has no effect.
- IDLE, i_track=2, rec key; stop key when i_rec_addr=0x80123 (ADDR_W=20, N_TRACKS=4) -> o_rec_start pulse, o_track_base=0x80000, o_sram_wr=1; then o_rec_stop pulse, len[2]=0x0123, state=IDLE.
- Play track 2, i_speed=3, i_fast=1; i_play_addr ramps to 0x80123 -> o_dsp_start pulse, o_play_en=1, o_speed=3, o_track_end=0x80123; then o_dsp_stop and o_done pulses, o_play_en=0, IDLE.
- Play key with i_track=1 after reset-only init -> o_err pulse, no o_dsp_start, state stays IDLE.
- Record track 2, i_rec_addr reaches 0xBFFFF -> auto o_rec_stop and o_done, len[2]=0x3FFFF.
- In PLAY: play key (pause), i_speed changed to 5, play key -> o_dsp_pause, then o_dsp_start with o_speed=5. Stop and play keys in the same cycle -> only o_dsp_stop, state=IDLE.
